// File: rtl/femto_bus_fabric.sv
// femto_bus_fabric: page-decoding interconnect between the FemtoRV32 memory port and N slaves,
// with busy forwarding and a watchdog. Define FEMTO_BUS_ERRCAP_EN for error-capture registers.
module femto_bus_fabric #(
    parameter int                     N_SLAVES      = 4,
    parameter int                     PAGE_HI       = 31,
    parameter int                     PAGE_LO       = 16,
    parameter logic [16*N_SLAVES-1:0] BASE_TABLE    = {16'h0043, 16'h0040, 16'h0001, 16'h0000},
    parameter int                     DEFAULT_SLAVE = 0,
    parameter int                     TIMEOUT       = 1024,
    parameter logic [31:0]            ERR_DATA      = 32'hDEADBEEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    input  logic [3:0]                mem_wmask,
    input  logic                      mem_rstrb,
    output logic [31:0]               mem_rdata,
    output logic                      mem_rbusy,
    output logic                      mem_wbusy,
    output logic [N_SLAVES-1:0]       s_cs,
    output logic [N_SLAVES-1:0]       s_rd,
    output logic [N_SLAVES-1:0]       s_wr,
    input  logic [N_SLAVES-1:0][31:0] s_rdata,
    input  logic [N_SLAVES-1:0]       s_rbusy,
    input  logic [N_SLAVES-1:0]       s_wbusy,
    output logic                      bus_err
);
    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       sel_q, sel_d;
    logic [IW-1:0]       dec_idx, rd_sel;
    logic [15:0]         page;
    logic [N_SLAVES-1:0] hit;
    logic                cap_hit;
    logic                wr_req;
    logic                slv_busy;
    logic                to;
    logic                unused_ok;

    // Write data goes straight to the slaves outside this block; only the page bits are decoded.
    assign unused_ok = ^{mem_wdata, mem_addr};

    assign page   = 16'(mem_addr[PAGE_HI:PAGE_LO]);
    assign wr_req = |mem_wmask;

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_match
        assign hit[i] = (page == BASE_TABLE[16*i +: 16]);
    end

    // Scan downwards so the lowest matching slot is the last one written.
    always_comb begin
        dec_idx = IW'(DEFAULT_SLAVE);
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) dec_idx = IW'(i);
        end
    end

`ifdef FEMTO_BUS_ERRCAP_EN
    assign cap_hit = (page == 16'h00FF);
`else
    assign cap_hit = 1'b0;
`endif

    assign s_cs = cap_hit ? '0 : (N_SLAVES'(1) << dec_idx);
    assign s_rd = s_cs & {N_SLAVES{mem_rstrb}};
    assign s_wr = s_cs & {N_SLAVES{wr_req}};

    always_comb begin
        slv_busy = 1'b0;
        case (state_q)
            RD_WAIT: slv_busy = s_rbusy[sel_q];
            WR_WAIT: slv_busy = s_wbusy[sel_q];
            default: slv_busy = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                sel_d = dec_idx;
                if (!cap_hit) begin
                    if (wr_req)         state_d = WR_WAIT;
                    else if (mem_rstrb) state_d = RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: if (!slv_busy || to) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            sel_q   <= IW'(DEFAULT_SLAVE);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    if (TIMEOUT > 0) begin : g_wdog
        localparam int            CW   = $clog2(TIMEOUT + 1);
        localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
        localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
        logic [CW-1:0] cnt_q, cnt_d;

        // Held at zero while idle, so every transaction starts with a fresh budget.
        always_comb begin
            cnt_d = cnt_q;
            if (state_q == IDLE)                 cnt_d = '0;
            else if (slv_busy && cnt_q != SAT)   cnt_d = cnt_q + 1'b1;
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) cnt_q <= '0;
            else         cnt_q <= cnt_d;
        end

        assign to = slv_busy && (cnt_q == LAST);
    end else begin : g_no_wdog
        assign to = 1'b0;
    end

    assign mem_rbusy = (state_q == RD_WAIT) && slv_busy && !to;
    assign mem_wbusy = (state_q == WR_WAIT) && slv_busy && !to;
    assign bus_err   = to;

    // Idle reads use the live decode so zero-wait slaves answer in the strobe cycle.
    assign rd_sel = (state_q == IDLE) ? dec_idx : sel_q;

`ifdef FEMTO_BUS_ERRCAP_EN
    logic [31:0] addr_q, addr_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        err_flag_q, err_flag_d;

    always_comb begin
        addr_d     = (state_q == IDLE) ? mem_addr : addr_q;
        err_addr_d = err_addr_q;
        err_flag_d = err_flag_q;
        if (to) begin
            err_addr_d = addr_q;
            err_flag_d = 1'b1;
        end else if (state_q == IDLE && cap_hit && wr_req) begin
            err_addr_d = '0;
            err_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '0;
            err_addr_q <= '0;
            err_flag_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            err_addr_q <= err_addr_d;
            err_flag_q <= err_flag_d;
        end
    end

    always_comb begin
        mem_rdata = s_rdata[rd_sel];
        if (to)
            mem_rdata = ERR_DATA;
        else if (state_q == IDLE && cap_hit)
            mem_rdata = mem_addr[2] ? err_addr_q : {31'b0, err_flag_q};
    end
`else
    always_comb begin
        mem_rdata = s_rdata[rd_sel];
        if (to) mem_rdata = ERR_DATA;
    end
`endif

endmodule

// File: tb/tb_femto_bus_fabric.sv
// Bench for femto_bus_fabric: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_femto_bus_fabric;
  localparam int N = 4;
  localparam int TO = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
`ifdef FEMTO_BUS_ERRCAP_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0] mem_wmask = '0;
  logic mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic mem_rbusy, mem_wbusy, bus_err;
  logic [N-1:0] s_cs, s_rd, s_wr;
  logic [N-1:0][31:0] s_rdata;
  logic [N-1:0] s_rbusy = '0, s_wbusy = '0;
  logic [31:0] rdata2;
  logic rbusy2, wbusy2, err2;
  logic [N-1:0] cs2, rd2, wr2;

  always #5 clk = ~clk;

  femto_bus_fabric #(.N_SLAVES(N), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .s_cs(s_cs), .s_rd(s_rd), .s_wr(s_wr),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .bus_err(bus_err));

  // Overlapping table: slots 1 and 3 both claim page 0x0040.
  femto_bus_fabric #(.N_SLAVES(N),
    .BASE_TABLE({16'h0040, 16'h0007, 16'h0040, 16'h0000})) dut_ovl (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(rdata2),
    .mem_rbusy(rbusy2), .mem_wbusy(wbusy2), .s_cs(cs2), .s_rd(rd2), .s_wr(wr2),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .bus_err(err2));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int tbl[N] = '{16'h0000, 16'h0001, 16'h0040, 16'h0043};
  int m_kind = 0;          // 0 none, 1 read pending, 2 write pending
  int m_sel = 0, m_wait = 0;
  logic [31:0] m_addr = '0, m_eaddr = '0;
  logic m_eflag = 1'b0;
  logic e_cap, e_sb, e_to;
  int e_idx;
  logic [N-1:0] e_cs;
  logic [31:0] e_rd;

  function automatic int dec(input logic [31:0] a);
    int r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) if (a[31:16] == tbl[i][15:0]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      m_kind = 0; m_sel = 0; m_wait = 0; m_addr = '0; m_eflag = 1'b0; m_eaddr = '0;
    end
    e_cap = CAP && (mem_addr[31:16] == 16'h00FF);
    e_idx = dec(mem_addr);
    e_cs = '0;
    if (!e_cap) e_cs[e_idx] = 1'b1;
    e_sb = 1'b0;
    if (m_kind == 1) e_sb = s_rbusy[m_sel];
    else if (m_kind == 2) e_sb = s_wbusy[m_sel];
    e_to = e_sb && (m_wait == TO - 1);
    if (m_kind == 0) e_rd = e_cap ? (mem_addr[2] ? m_eaddr : {31'b0, m_eflag}) : s_rdata[e_idx];
    else             e_rd = e_to ? ERR : s_rdata[m_sel];
    chk("m_s_cs", 32'(s_cs), 32'(e_cs));
    chk("m_s_rd", 32'(s_rd), 32'(mem_rstrb ? e_cs : '0));
    chk("m_s_wr", 32'(s_wr), 32'((|mem_wmask) ? e_cs : '0));
    chk("m_rdata", mem_rdata, e_rd);
    chk("m_rbusy", 32'(mem_rbusy), 32'(m_kind == 1 && e_sb && !e_to));
    chk("m_wbusy", 32'(mem_wbusy), 32'(m_kind == 2 && e_sb && !e_to));
    chk("m_bus_err", 32'(bus_err), 32'(e_to));
    if (resetn) begin
      if (m_kind != 0) begin
        if (!e_sb || e_to) begin
          if (e_to) begin m_eflag = 1'b1; m_eaddr = m_addr; end
          m_kind = 0;
        end else m_wait++;
      end else if (e_cap) begin
        if (|mem_wmask) begin m_eflag = 1'b0; m_eaddr = '0; end
      end else if (|mem_wmask) begin
        m_kind = 2; m_sel = e_idx; m_wait = 0; m_addr = mem_addr;
      end else if (mem_rstrb) begin
        m_kind = 1; m_sel = e_idx; m_wait = 0; m_addr = mem_addr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic quiet();
    mem_rstrb = 1'b0;
    mem_wmask = 4'h0;
  endtask

  int first, cnt;
  logic [N-1:0] stuck_r, stuck_w;
  logic [15:0] pg;

  initial begin
    for (int i = 0; i < N; i++) s_rdata[i] = 32'hA0 + i;
    s_rdata[1] = 32'h41;
    tick(); tick();
    @(negedge clk);
    chk("rst_rbusy", 32'(mem_rbusy), 0);
    chk("rst_wbusy", 32'(mem_wbusy), 0);
    chk("rst_err", 32'(bus_err), 0);
    chk("rst_rdata", mem_rdata, 32'hA0);
    tick(); resetn = 1'b1;

    // zero-wait read of slave 1
    tick(); mem_addr = 32'h00010004; mem_rstrb = 1'b1;
    @(negedge clk);
    chk("rd1_s_rd", 32'(s_rd), 32'b0010);
    chk("rd1_rdata", mem_rdata, 32'h41);
    chk("rd1_rbusy", 32'(mem_rbusy), 0);
    tick(); quiet();
    @(negedge clk);
    chk("rd1_rbusy_after", 32'(mem_rbusy), 0);

    // slave 0 busy for 7 cycles
    tick(); mem_addr = 32'h00000010; mem_rstrb = 1'b1; s_rbusy[0] = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(); quiet(); s_rbusy[0] = (k <= 7);
      @(negedge clk);
      if (mem_rbusy) cnt++;
      if (k == 8) begin
        chk("rd0_drop_rbusy", 32'(mem_rbusy), 0);
        chk("rd0_rdata", mem_rdata, 32'hA0);
      end
    end
    chk("rd0_busy_cycles", cnt, 7);

    // stuck write to slave 2 -> watchdog
    tick(); mem_addr = 32'h00400000; mem_wmask = 4'hF; s_wbusy[2] = 1'b1;
    @(negedge clk);
    chk("wr2_s_wr", 32'(s_wr), 32'b0100);
    first = 0; cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(); quiet();
      @(negedge clk);
      if (bus_err) cnt++;
      if (!mem_wbusy && first == 0) begin
        first = k;
        chk("wr2_to_rdata", mem_rdata, ERR);
      end
    end
    chk("wr2_drop_cycle", first, 16);
    chk("wr2_err_pulses", cnt, 1);
    s_wbusy[2] = 1'b0;
    tick(); mem_addr = 32'h00000000; mem_rstrb = 1'b1;
    @(negedge clk);
    chk("post_to_rdata", mem_rdata, 32'hA0);
    tick(); quiet();
    @(negedge clk);
    chk("post_to_rbusy", 32'(mem_rbusy), 0);

    // unmapped page and overlapping table
    tick(); mem_addr = 32'h12340000; mem_rstrb = 1'b1;
    @(negedge clk);
    chk("unmapped_cs", 32'(s_cs), 32'b0001);
    tick(); mem_addr = 32'h00400000; mem_rstrb = 1'b0;
    @(negedge clk);
    chk("overlap_cs", 32'(cs2), 32'b0010);

    // reset in the middle of a read wait
    tick(); mem_addr = 32'h00430000; mem_rstrb = 1'b1; s_rbusy[3] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(); quiet();
    end
    @(negedge clk);
    chk("mid_rbusy_pre", 32'(mem_rbusy), 1);
    tick(); resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_rbusy", 32'(mem_rbusy), 0);
    tick(); resetn = 1'b1;
    tick(); mem_rstrb = 1'b1;
    @(negedge clk);
    chk("rd3_s_rd", 32'(s_rd), 32'b1000);
    cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      tick(); quiet(); s_rbusy[3] = (k <= 2);
      @(negedge clk);
      if (mem_rbusy) cnt++;
    end
    chk("rd3_rbusy_cycles", cnt, 2);
    chk("rd3_rdata", mem_rdata, 32'hA3);

`ifdef FEMTO_BUS_ERRCAP_EN
    tick(); mem_addr = 32'h00430008; mem_rstrb = 1'b1; s_rbusy[3] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(); quiet();
    end
    s_rbusy[3] = 1'b0;
    tick(); mem_addr = 32'h00FF0000; mem_rstrb = 1'b1;
    @(negedge clk);
    chk("cap_flag", mem_rdata, 32'h1);
    chk("cap_cs", 32'(s_cs), 0);
    tick(); mem_addr = 32'h00FF0004;
    @(negedge clk);
    chk("cap_addr", mem_rdata, 32'h00430008);
    chk("cap_rbusy", 32'(mem_rbusy), 0);
    tick(); mem_addr = 32'h00FF0000; mem_rstrb = 1'b0; mem_wmask = 4'hF;
    tick(); quiet(); mem_rstrb = 1'b1;
    @(negedge clk);
    chk("cap_flag_clr", mem_rdata, 32'h0);
    tick(); mem_addr = 32'h00FF0004;
    @(negedge clk);
    chk("cap_addr_clr", mem_rdata, 32'h0);
`endif

    // randomized traffic
    stuck_r = '0; stuck_w = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 64 == 0) begin
        stuck_r = 4'($urandom & $urandom);
        stuck_w = 4'($urandom & $urandom);
      end
      resetn = ($urandom_range(0, 299) != 0);
      case ($urandom_range(0, 5))
        0: pg = 16'h0000;
        1: pg = 16'h0001;
        2: pg = 16'h0040;
        3: pg = 16'h0043;
        4: pg = 16'h00FF;
        default: pg = 16'($urandom);
      endcase
      mem_addr = {pg, 16'($urandom)};
      mem_wdata = $urandom;
      mem_rstrb = ($urandom_range(0, 3) == 0);
      mem_wmask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      for (int i = 0; i < N; i++) begin
        s_rdata[i] = $urandom;
        s_rbusy[i] = stuck_r[i] | 1'($urandom_range(0, 1));
        s_wbusy[i] = stuck_w[i] | 1'($urandom_range(0, 1));
      end
    end
    tick(); resetn = 1'b1; quiet();
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
